// File: rtl/fpu_add_pkg.sv
// Shared types and constants for the floating-point add scheduler and its datapath.
package fpu_add_pkg;

    // Depth of the align / add / normalize-round datapath.
    localparam int unsigned ADD_STAGES = 3;

    typedef enum logic [2:0] {
        FrmRne = 3'd0,
        FrmRtz = 3'd1,
        FrmRdn = 3'd2,
        FrmRup = 3'd3,
        FrmRmm = 3'd4
    } fpu_frm_t;

    typedef struct packed {
        logic nv;
        logic ovf;
        logic unf;
        logic nx;
        logic dz;
    } fpu_flags_t;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        sub;
        fpu_frm_t    frm;
    } add_req_t;

    // Subtraction is an addition with the second operand's sign inverted.
    function automatic logic [31:0] apply_sub(input logic [31:0] op2, input logic sub);
        return {op2[31] ^ sub, op2[30:0]};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves past the winner only when a grant is issued.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       gnt_vld_o,
    output logic       gnt_id_o
);

    logic ptr_q, ptr_d;

    // Pick the winner: a lone requester wins, ties go to the pointer.
    always_comb begin
        gnt_vld_o = en_i & (|req_i);
        case (req_i)
            2'b01:   gnt_id_o = 1'b0;
            2'b10:   gnt_id_o = 1'b1;
            2'b11:   gnt_id_o = ptr_q;
            default: gnt_id_o = 1'b0;
        endcase
        gnt_o = 2'b00;
        if (gnt_vld_o) begin
            gnt_o = gnt_id_o ? 2'b10 : 2'b01;
        end
    end

    // Priority passes to the other requester after every grant.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld_o) begin
            ptr_d = ~gnt_id_o;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpu_add_sched.sv
// Shares one pipelined FP add datapath between two requesters: arbitrates, tracks the
// owner of each in-flight op, stalls the whole pipe on result backpressure and routes
// results back to their owner.
module fpu_add_sched
    import fpu_add_pkg::*;
#(
    parameter int unsigned STAGES = ADD_STAGES
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [31:0]       req0_op1,
    input  logic [31:0]       req0_op2,
    input  logic              req0_sub,
    input  logic [2:0]        req0_frm,
    input  logic [31:0]       req1_op1,
    input  logic [31:0]       req1_op2,
    input  logic              req1_sub,
    input  logic [2:0]        req1_frm,
    output logic [31:0]       dp_op1,
    output logic [31:0]       dp_op2,
    output logic [2:0]        dp_frm,
    output logic [STAGES-1:0] stage_en,
    input  logic [31:0]       dp_result,
    input  logic [4:0]        dp_flags,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    input  logic              rsp0_ready,
    input  logic              rsp1_ready,
    output logic [31:0]       rsp0_result,
    output logic [4:0]        rsp0_flags,
    output logic [31:0]       rsp1_result,
    output logic [4:0]        rsp1_flags,
    output logic              busy
);

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] id_q, id_d;

    logic     tail_vld, tail_id, tail_fire, advance;
    logic     gnt_vld, gnt_id;
    logic [1:0] gnt;
    add_req_t req0, req1, req_sel;

    assign req0 = '{op1: req0_op1, op2: req0_op2, sub: req0_sub, frm: fpu_frm_t'(req0_frm)};
    assign req1 = '{op1: req1_op1, op2: req1_op2, sub: req1_sub, frm: fpu_frm_t'(req1_frm)};

    // Pipeline movement: every stage moves together unless the tail result is blocked.
    // Reset is folded in so nothing is offered or enabled while nRST is low.
    always_comb begin
        tail_vld  = vld_q[STAGES-1];
        tail_id   = id_q[STAGES-1];
        tail_fire = tail_vld & (tail_id ? rsp1_ready : rsp0_ready);
        advance   = (~tail_vld | tail_fire) & nRST;
    end

    rr_arbiter2 u_arb (
        .clk_i     (CLK),
        .rst_ni    (nRST),
        .en_i      (advance & ~flush),
        .req_i     ({req1_valid, req0_valid}),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    // Stage tracker next state: shift valid/owner on advance, flush kills every op.
    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        if (advance) begin
            vld_d = (vld_q << 1) | STAGES'(gnt_vld);
            id_d  = (id_q << 1) | STAGES'(gnt_id);
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    // Stage tracker registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    // Operand mux to step1; zero when nothing is granted.
    always_comb begin
        req_sel = '0;
        if (gnt_vld) begin
            req_sel = gnt_id ? req1 : req0;
        end
        dp_op1 = req_sel.op1;
        dp_op2 = apply_sub(req_sel.op2, req_sel.sub);
        dp_frm = req_sel.frm;
    end

    // Handshake, enables and result routing.
    always_comb begin
        req0_ready  = gnt[0];
        req1_ready  = gnt[1];
        stage_en    = {STAGES{advance}};
        rsp0_valid  = tail_vld & ~tail_id;
        rsp1_valid  = tail_vld & tail_id;
        rsp0_result = dp_result;
        rsp1_result = dp_result;
        rsp0_flags  = dp_flags;
        rsp1_flags  = dp_flags;
        busy        = |vld_q;
    end

endmodule

// File: tb/tb_fpu_add_sched.sv
// Self-checking bench for fpu_add_sched with a stand-in datapath and a queue-based model.
module tb_fpu_add_sched;

    localparam int unsigned S = 3;

    logic          CLK, nRST, flush;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0]   req0_op1, req0_op2, req1_op1, req1_op2;
    logic          req0_sub, req1_sub;
    logic [2:0]    req0_frm, req1_frm;
    logic [31:0]   dp_op1, dp_op2;
    logic [2:0]    dp_frm;
    logic [S-1:0]  stage_en;
    logic [31:0]   dp_result;
    logic [4:0]    dp_flags;
    logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0]   rsp0_result, rsp1_result;
    logic [4:0]    rsp0_flags, rsp1_flags;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    fpu_add_sched #(.STAGES(S)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sub(req0_sub), .req0_frm(req0_frm),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sub(req1_sub), .req1_frm(req1_frm),
        .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_frm(dp_frm), .stage_en(stage_en),
        .dp_result(dp_result), .dp_flags(dp_flags),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in datapath: a recognisable combine of the operands, held when not enabled.
    logic [31:0] pipe_q [S];
    always_ff @(posedge CLK) begin
        if (stage_en[0]) pipe_q[0] <= dp_op1 ^ dp_op2 ^ {29'b0, dp_frm};
        for (int i = 1; i < S; i++) begin
            if (stage_en[i]) pipe_q[i] <= pipe_q[i-1];
        end
    end
    assign dp_result = pipe_q[S-1];
    assign dp_flags  = pipe_q[S-1][4:0];

    // Result the stand-in datapath should produce for a request.
    function automatic logic [31:0] exp_val(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub, input logic [2:0] frm);
        return a ^ (b ^ {sub, 31'b0}) ^ {29'b0, frm};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; flush = 0;
        req0_op1 = 0; req0_op2 = 0; req0_sub = 0; req0_frm = 0;
        req1_op1 = 0; req1_op2 = 0; req1_sub = 0; req1_frm = 0;
        rsp0_ready = 1; rsp1_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        req0_valid = 1; req0_op1 = 32'h1234_5678;
        nRST = 0;
        #3;
        n_checks++; if (req0_ready !== 1'b0) $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); else n_pass++;
        n_checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", {rsp0_valid, rsp1_valid}); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (dp_op1 !== 32'h0) $display("FAIL reset_dp_op1 got=%h exp=0", dp_op1); else n_pass++;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1;
        req0_valid = 0;
    endtask

    task automatic test_single();
        req0_valid = 1; req0_op1 = 32'h3F80_0000; req0_op2 = 32'h4000_0000; req0_sub = 0; req0_frm = 3'd0;
        #1;
        n_checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL single_ready got=%b exp=01", {req1_ready, req0_ready}); else n_pass++;
        n_checks++; if (dp_op2 !== 32'h4000_0000) $display("FAIL single_dp_op2 got=%h exp=40000000", dp_op2); else n_pass++;
        n_checks++; if (stage_en !== 3'b111) $display("FAIL single_stage_en got=%b exp=111", stage_en); else n_pass++;
        tick();
        req0_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_checks++; if (rsp0_valid !== (k == 3)) $display("FAIL single_rsp0_valid_%0d got=%b exp=%b", k, rsp0_valid, k == 3); else n_pass++;
            n_checks++; if (rsp1_valid !== 1'b0) $display("FAIL single_rsp1_valid_%0d got=%b exp=0", k, rsp1_valid); else n_pass++;
            if (k == 3) begin
                n_checks++; if (rsp0_result !== 32'h7F80_0000) $display("FAIL single_result got=%h exp=7f800000", rsp0_result); else n_pass++;
            end
            tick();
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_sub();
        req1_valid = 1; req1_op1 = 32'h3F80_0000; req1_op2 = 32'h4000_0000; req1_sub = 1; req1_frm = 3'd1;
        #1;
        n_checks++; if (req1_ready !== 1'b1) $display("FAIL sub_req1_ready got=%b exp=1", req1_ready); else n_pass++;
        n_checks++; if (dp_op2 !== 32'hC000_0000) $display("FAIL sub_dp_op2 got=%h exp=c0000000", dp_op2); else n_pass++;
        n_checks++; if (dp_frm !== 3'd1) $display("FAIL sub_dp_frm got=%0d exp=1", dp_frm); else n_pass++;
        tick();
        req1_valid = 0;
        tick(); tick();
        #1;
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b10) $display("FAIL sub_rsp_valid got=%b exp=10", {rsp1_valid, rsp0_valid}); else n_pass++;
        n_checks++; if (rsp1_result !== exp_val(32'h3F80_0000, 32'h4000_0000, 1'b1, 3'd1)) $display("FAIL sub_result got=%h exp=%h", rsp1_result, exp_val(32'h3F80_0000, 32'h4000_0000, 1'b1, 3'd1)); else n_pass++;
        tick();
    endtask

    task automatic test_contention();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            req0_valid = (c < 8); req1_valid = (c < 8);
            req0_op1 = 32'h100 + c; req1_op1 = 32'h100 + c;
            #1;
            if (c < 8) begin
                n_checks++; if ({req1_ready, req0_ready} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL contend_grant_%0d got=%b", c, {req1_ready, req0_ready}); else n_pass++;
            end
            if (c >= 3 && c < 11) begin
                n_checks++; if ({rsp1_valid, rsp0_valid} !== (((c - 3) % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL contend_rsp_%0d got=%b", c, {rsp1_valid, rsp0_valid}); else n_pass++;
                n_checks++; if (rsp0_result !== 32'h100 + c - 3) $display("FAIL contend_result_%0d got=%h exp=%h", c, rsp0_result, 32'h100 + c - 3); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ops [3];
        ops[0] = 32'hAAAA_0001; ops[1] = 32'hBBBB_0002; ops[2] = 32'hCCCC_0003;
        rsp0_ready = 0;
        for (int c = 0; c < 3; c++) begin
            req0_valid = 1; req0_op1 = ops[c]; req0_op2 = 0;
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            req0_valid = 1; req1_valid = 1; req0_op1 = 32'hDEAD_0000; req1_op1 = 32'hBEEF_0000;
            #1;
            n_checks++; if (stage_en !== 3'b000) $display("FAIL bp_stage_en_%0d got=%b exp=000", c, stage_en); else n_pass++;
            n_checks++; if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL bp_ready_%0d got=%b exp=00", c, {req1_ready, req0_ready}); else n_pass++;
            n_checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== ops[0]) $display("FAIL bp_hold_%0d got=%b/%h exp=1/%h", c, rsp0_valid, rsp0_result, ops[0]); else n_pass++;
            tick();
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (rsp0_valid !== (c < 3)) $display("FAIL bp_drain_valid_%0d got=%b exp=%b", c, rsp0_valid, c < 3); else n_pass++;
            if (c < 3) begin
                n_checks++; if (rsp0_result !== ops[c]) $display("FAIL bp_drain_result_%0d got=%h exp=%h", c, rsp0_result, ops[c]); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_flush();
        req0_valid = 1; req0_op1 = 32'h0F0F_0000;
        tick();
        req0_valid = 0; req1_valid = 1; req1_op1 = 32'hF0F0_0000;
        tick();
        req1_valid = 0; req0_valid = 1; flush = 1;
        #1;
        n_checks++; if (req0_ready !== 1'b0) $display("FAIL flush_req0_ready got=%b exp=0", req0_ready); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL flush_busy_before got=%b exp=1", busy); else n_pass++;
        tick();
        flush = 0; req0_valid = 0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL flush_busy_after got=%b exp=0", busy); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) $display("FAIL flush_no_rsp_%0d got=%b exp=00", c, {rsp1_valid, rsp0_valid}); else n_pass++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        rsp0_ready = 0;
        req0_valid = 1; req0_op1 = 32'h5555_0000;
        tick();
        req0_valid = 0;
        repeat (3) tick();
        req0_valid = 1;
        #1;
        n_checks++; if (rsp0_valid !== 1'b1) $display("FAIL areset_pre_valid got=%b exp=1", rsp0_valid); else n_pass++;
        nRST = 0;
        #1;
        n_checks++; if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid, busy} !== 5'b0) $display("FAIL areset_outputs got=%b exp=00000", {req1_ready, req0_ready, rsp1_valid, rsp0_valid, busy}); else n_pass++;
        n_checks++; if (stage_en !== 3'b000) $display("FAIL areset_stage_en got=%b exp=000", stage_en); else n_pass++;
        tick();
        nRST = 1; req0_valid = 0; rsp0_ready = 1;
        req1_valid = 1; req1_op1 = 32'h6666_0000; req1_op2 = 32'h0000_0001; req1_sub = 0; req1_frm = 0;
        #1;
        n_checks++; if (req1_ready !== 1'b1) $display("FAIL areset_regrant got=%b exp=1", req1_ready); else n_pass++;
        tick();
        req1_valid = 0;
        tick(); tick();
        #1;
        n_checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h6666_0001) $display("FAIL areset_rsp got=%b/%h exp=1/66660001", rsp1_valid, rsp1_result); else n_pass++;
        tick();
    endtask

    typedef struct {
        logic        id;
        logic [31:0] val;
        int unsigned stamp;
    } ent_t;

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        int unsigned adv_total;
        logic        m_ptr, out_v, out_id, adv, g_v, g_id;
        logic [31:0] g_val, g_op2;
        do_reset();
        q.delete();
        adv_total = 0;
        m_ptr = 0;
        for (int c = 0; c < 400; c++) begin
            req0_valid = ($urandom_range(0, 2) != 0); req1_valid = ($urandom_range(0, 2) != 0);
            req0_op1 = $urandom; req0_op2 = $urandom; req0_sub = 1'($urandom_range(0, 1)); req0_frm = 3'($urandom_range(0, 4));
            req1_op1 = $urandom; req1_op2 = $urandom; req1_sub = 1'($urandom_range(0, 1)); req1_frm = 3'($urandom_range(0, 4));
            rsp0_ready = ($urandom_range(0, 3) != 0); rsp1_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            #1;
            out_v  = (q.size() > 0) && (adv_total - q[0].stamp == S);
            out_id = out_v ? q[0].id : 1'b0;
            adv    = !out_v || (out_id ? rsp1_ready : rsp0_ready);
            g_v    = adv && !flush && (req0_valid || req1_valid);
            g_id   = (req0_valid && req1_valid) ? m_ptr : req1_valid;
            g_val  = g_id ? exp_val(req1_op1, req1_op2, req1_sub, req1_frm)
                          : exp_val(req0_op1, req0_op2, req0_sub, req0_frm);
            g_op2  = g_id ? (req1_op2 ^ {req1_sub, 31'b0}) : (req0_op2 ^ {req0_sub, 31'b0});
            n_checks++; if ({req1_ready, req0_ready} !== {g_v & g_id, g_v & ~g_id}) $display("FAIL rnd_ready_%0d got=%b exp=%b", c, {req1_ready, req0_ready}, {g_v & g_id, g_v & ~g_id}); else n_pass++;
            n_checks++; if ({rsp1_valid, rsp0_valid} !== {out_v & out_id, out_v & ~out_id}) $display("FAIL rnd_rsp_valid_%0d got=%b exp=%b", c, {rsp1_valid, rsp0_valid}, {out_v & out_id, out_v & ~out_id}); else n_pass++;
            n_checks++; if (stage_en !== {S{adv}}) $display("FAIL rnd_stage_en_%0d got=%b exp=%b", c, stage_en, {S{adv}}); else n_pass++;
            n_checks++; if (busy !== (q.size() > 0)) $display("FAIL rnd_busy_%0d got=%b exp=%b", c, busy, q.size() > 0); else n_pass++;
            if (out_v) begin
                n_checks++; if ((out_id ? rsp1_result : rsp0_result) !== q[0].val) $display("FAIL rnd_result_%0d got=%h exp=%h", c, out_id ? rsp1_result : rsp0_result, q[0].val); else n_pass++;
                n_checks++; if ((out_id ? rsp1_flags : rsp0_flags) !== q[0].val[4:0]) $display("FAIL rnd_flags_%0d got=%h exp=%h", c, out_id ? rsp1_flags : rsp0_flags, q[0].val[4:0]); else n_pass++;
            end
            if (g_v) begin
                n_checks++; if (dp_op2 !== g_op2) $display("FAIL rnd_dp_op2_%0d got=%h exp=%h", c, dp_op2, g_op2); else n_pass++;
            end
            if (adv) begin
                if (out_v) void'(q.pop_front());
                if (g_v) begin
                    e.id = g_id; e.val = g_val; e.stamp = adv_total;
                    q.push_back(e);
                end
                adv_total++;
            end
            if (flush) q.delete();
            if (g_v) m_ptr = ~g_id;
            @(posedge CLK);
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_sub();
        test_contention();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_add_sched.md
# fpu_add_sched

Scheduler that shares the single three-stage floating-point add datapath (align → signed fraction add → normalize/round) between two requesters. It arbitrates round-robin and injects at most one operation per cycle. It tracks each in-flight operation's valid bit and owner ID through the stages, drives the stage load enables, and routes each result back to the owning requester with backpressure. It sits between the FPU issue logic / FMA accumulate path and the adder step modules.

## Interface
- `STAGES`, default 3: pipeline depth of the add datapath (step1..step3); the result is valid at the output of the last stage.
- `CLK` in 1: single clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous kill of all in-flight operations.
- `req0_valid`, `req1_valid` in 1: requester has an operation.
- `req0_ready`, `req1_ready` out 1: operation accepted this cycle (fire = valid & ready).
- `reqN_op1`, `reqN_op2` in 32: IEEE-754 single operands.
- `reqN_sub` in 1: 1 = op1 − op2.
- `reqN_frm` in 3: rounding mode.
- `dp_op1`, `dp_op2` out 32: operands to step1; `dp_op2[31]` is inverted when the granted request has `sub`=1.
- `dp_frm` out 3: rounding mode of the granted request.
- `stage_en` out STAGES: load enable for each datapath stage register.
- `dp_result` in 32: last-stage result from the datapath.
- `dp_flags` in 5: last-stage exception flags (NV, OF, UF, NX, DZ).
- `rsp0_valid`, `rsp1_valid` out 1: result for that requester.
- `rsp0_ready`, `rsp1_ready` in 1: requester accepts the result.
- `rspN_result` out 32 and `rspN_flags` out 5: fanned out from `dp_result` / `dp_flags`.
- `busy` out 1: any stage valid.

## Operation
- State per stage i: `vld[i]` and `id[i]` (0/1). Arbiter state: `rr_ptr` (1 bit), the requester with priority.
- `tail_fire = vld[S-1] & rspX_ready`, where X = `id[S-1]`.
- `advance = ~vld[S-1] | tail_fire`. Global stall: all stages move together.
- `stage_en[i] = advance` for all i. The datapath holds its registers when `advance`=0.
- Grant, only when `advance & ~flush`:
  - one requester valid → that requester;
  - both valid → `rr_ptr`.
- `reqN_ready = grant==N`. A grant fires by definition because it requires `valid`.
- After a fire, `rr_ptr` ← ~granted ID. With no fire, `rr_ptr` holds.
- On `advance`:
  - `vld[0]` ← fire, `id[0]` ← granted ID;
  - `vld[i]` ← `vld[i-1]`, `id[i]` ← `id[i-1]`.
- `rspN_valid = vld[S-1] & id[S-1]==N`. The other response valid is 0.
- `dp_op1`, `dp_op2`, `dp_frm` mux from the granted requester. They are don't-care (drive 0) when there is no grant.
- `flush`=1: all `vld` ← 0 at the next edge, `rr_ptr` holds, no requests accepted that cycle. Any `rsp_valid` in the flush cycle is still presented and may fire. The requester must discard it.
- Simultaneous tail fire and new grant: legal. This is full throughput, one op per cycle.
- Reset (async) or `nRST` low mid-operation: all `vld`=0, all `id`=0, `rr_ptr`=0, all ready/valid outputs 0, `busy`=0. In-flight ops are lost.

## Timing
- Accepted at edge N → `rspX_valid` high after edge N+STAGES if not stalled. Every stalled cycle adds one.
- The `ready` outputs are combinational from `rsp_ready`, `valid`, `flush` and state. There is no path from `req_valid` to `rsp_valid`.
- Throughput: 1 op/cycle with no stall.
- Once asserted, `rspN_valid` and the result stay stable until it fires or `flush`. The datapath holds its registers on stall.
- `busy` is registered-state-derived: OR of `vld`.

## Structure
- Shared package `fpu_add_pkg`:
  - `ADD_STAGES` = 3;
  - `fpu_frm_t` (3-bit enum RNE, RTZ, RDN, RUP, RMM);
  - `fpu_flags_t` packed struct;
  - `add_req_t` struct {op1, op2, sub, frm}.
- One natural sub-module, `rr_arbiter2`: 2-way round-robin arbiter with an enable input and grant-fire pointer update.
- The stage tracker is inline shift registers.

## Test plan
- Single op: req0 op1=0x3F800000 (1.0), op2=0x40000000 (2.0), sub=0 → `dp_op2`=0x40000000, `stage_en`=3'b111, `rsp0_valid` 3 cycles later, `rsp1_valid` stays 0.
- Subtract flip: req1 op2=0x40000000, sub=1 → `dp_op2`=0xC0000000 in the grant cycle. Response appears on rsp1 only.
- Contention: both valid every cycle from reset → grants 0,1,0,1… The response IDs emerge in the same order 3 cycles later.
- Backpressure: three ops in flight and `rsp0_ready`=0 for 4 cycles → `stage_en`=0, both `req_ready`=0, `rsp0_result` stable. Releasing ready drains one per cycle.
- Flush with 2 in flight plus a req valid → that req is not accepted, and 0 responses follow. `busy` drops next cycle.
- Async reset asserted mid-stall → all outputs 0 immediately with no clock edge. After release, the first request is granted normally.
